// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the binary-tree NoC blocks.
//   PKT_W            packet width
//   ADDR_HI/ADDR_LO  position of the 4-bit destination address in a packet
//   pkt_t            packet type
//   arb_state_t      merge arbiter FSM states
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int PKT_W   = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 5;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_SEL  = 2'd1,
        SEND_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin grant selection.
//   valid0, valid1  request from input 0 / input 1
//   last            index of the most recent winner
//   grant           index of the selected input
//   grant_valid     at least one request is present
// On a conflict the input that did not win last time is chosen.
// -----------------------------------------------------------------------------
module rr_arb2
    import noc_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last;
        end else begin
            grant = valid1;
        end
    end

endmodule

// File: rtl/noc_merge_arb2.sv
// -----------------------------------------------------------------------------
// noc_merge_arb2
// Two-input round-robin merge for the upward path of the binary-tree NoC.
// Each accepted packet is announced on S (winning input index) and then sent
// on Out, so a downstream decoder sees select-then-data in lock-step.
//
// Ports:
//   CLK, _RESET            clock, asynchronous active-low reset
//   In0_*, In1_*           child channels (data/valid in, ready out)
//   S_data/S_valid/S_ready select token channel (index of the granted input)
//   Out_data/valid/ready   parent packet channel
//   cnt0, cnt1             saturating per-input grant counters
//   dbg_state              current FSM state
//
// Handshake: a channel transfers on a CLK posedge where valid && ready are
// both high. Valid and data are held until that transfer and valid never
// depends combinationally on ready. Input readies are combinational: high
// only in IDLE and only for the granted input.
// -----------------------------------------------------------------------------
module noc_merge_arb2
    import noc_pkg::*;
#(
    parameter int W  = PKT_W,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          _RESET,
    input  logic [W-1:0]  In0_data,
    input  logic          In0_valid,
    output logic          In0_ready,
    input  logic [W-1:0]  In1_data,
    input  logic          In1_valid,
    output logic          In1_ready,
    output logic          S_data,
    output logic          S_valid,
    input  logic          S_ready,
    output logic [W-1:0]  Out_data,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output arb_state_t    dbg_state
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    arb_state_t   state;
    logic         last;
    logic         sel;
    logic [W-1:0] pkt_buf;

    logic grant;
    logic grant_valid;
    logic in_xfer;

    rr_arb2 u_rr_arb2 (
        .valid0      (In0_valid),
        .valid1      (In1_valid),
        .last        (last),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign In0_ready = (state == IDLE) && grant_valid && !grant;
    assign In1_ready = (state == IDLE) && grant_valid &&  grant;
    assign in_xfer   = (In0_valid && In0_ready) || (In1_valid && In1_ready);

    // Outputs come straight from registers: the state register decodes the
    // valids and sel/pkt_buf hold the data, so nothing depends on a ready.
    assign S_valid   = (state == SEND_SEL);
    assign S_data    = sel;
    assign Out_valid = (state == SEND_DATA);
    assign Out_data  = pkt_buf;
    assign dbg_state = state;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state   <= IDLE;
            last    <= 1'b1;   // makes In0 win the first conflict
            sel     <= 1'b0;
            pkt_buf <= '0;
            cnt0    <= '0;
            cnt1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        pkt_buf <= grant ? In1_data : In0_data;
                        sel     <= grant;
                        last    <= grant;
                        if (!grant && (cnt0 != CNT_MAX)) begin
                            cnt0 <= cnt0 + CNT_ONE;
                        end
                        if (grant && (cnt1 != CNT_MAX)) begin
                            cnt1 <= cnt1 + CNT_ONE;
                        end
                        state <= SEND_SEL;
                    end
                end
                SEND_SEL: begin
                    if (S_ready) begin
                        state <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (Out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
